// File: rtl/triumph_wb_stage.sv
// Writeback stage of the Triumph core: a 2-entry in-order result queue that
// waits on LSU data for loads, extends load lanes, and drives the RF write port.
module triumph_wb_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        res_valid_i,
   output logic        res_ready_o,
   input  logic [4:0]  res_rd_addr_i,
   input  logic [31:0] res_data_i,
   input  logic        res_is_load_i,
   input  logic [1:0]  res_load_size_i,
   input  logic        res_load_unsigned_i,
   input  logic [1:0]  res_addr_lo_i,
   input  logic        lsu_rvalid_i,
   input  logic [31:0] lsu_rdata_i,
   output logic        data_valid_wb_o,
   output logic [4:0]  rd_addr_wb_o,
   output logic [31:0] rd_data_wb_o,
   output logic        err_o
);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        is_load;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  addr_lo;
      logic        filled;
   } entry_t;

   entry_t      q [2];
   logic        head;
   logic        tail;
   logic [1:0]  count;

   logic        enq;
   logic        retire;
   logic        fill_head;
   logic        fill_next;
   logic        fill_hit;
   logic        fill_idx;
   logic [31:0] fill_data;

   function automatic logic [31:0] extract(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns,
                                           input logic [1:0]  lo);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = raw[7:0];
         2'd1:    b = raw[15:8];
         2'd2:    b = raw[23:16];
         default: b = raw[31:24];
      endcase
      h = lo[1] ? raw[31:16] : raw[15:0];
      case (size)
         2'b00:   extract = {{24{~uns & b[7]}}, b};
         2'b01:   extract = {{16{~uns & h[15]}}, h};
         default: extract = raw;
      endcase
   endfunction

   // The fill target is the oldest unfilled load among entries present before the edge.
   always_comb begin
      res_ready_o = (count != 2'd2);
      enq         = res_valid_i & res_ready_o;
      retire      = (count != 2'd0) & q[head].filled;
      fill_head   = (count != 2'd0) & q[head].is_load & ~q[head].filled;
      fill_next   = (count == 2'd2) & q[~head].is_load & ~q[~head].filled;
      fill_hit    = fill_head | fill_next;
      fill_idx    = fill_head ? head : ~head;
      fill_data   = extract(lsu_rdata_i, q[fill_idx].size, q[fill_idx].uns,
                            q[fill_idx].addr_lo);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 2; i++) begin
            q[i] <= '0;
         end
         head            <= 1'b0;
         tail            <= 1'b0;
         count           <= 2'd0;
         data_valid_wb_o <= 1'b0;
         rd_addr_wb_o    <= 5'd0;
         rd_data_wb_o    <= 32'd0;
         err_o           <= 1'b0;
      end else begin
         if (lsu_rvalid_i) begin
            if (fill_hit) begin
               q[fill_idx].filled <= 1'b1;
               q[fill_idx].data   <= fill_data;
            end else begin
               err_o <= 1'b1;
            end
         end

         // Enqueue and retire never touch the same slot: both require count == 1.
         if (enq) begin
            q[tail] <= '{rd:      res_rd_addr_i,
                         data:    res_data_i,
                         is_load: res_is_load_i,
                         size:    res_load_size_i,
                         uns:     res_load_unsigned_i,
                         addr_lo: res_addr_lo_i,
                         filled:  ~res_is_load_i};
            tail <= ~tail;
         end

         if (retire) begin
            q[head].filled  <= 1'b0;
            head            <= ~head;
            data_valid_wb_o <= (q[head].rd != 5'd0);
            rd_addr_wb_o    <= q[head].rd;
            rd_data_wb_o    <= q[head].data;
         end else begin
            data_valid_wb_o <= 1'b0;
         end

         case ({enq, retire})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_triumph_wb_stage.sv
// Scoreboard bench for triumph_wb_stage: expected writes are queued at acceptance
// and compared whenever the DUT pulses its register-file write port.
module tb_triumph_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [4:0]  res_rd = '0;
   logic [31:0] res_data = '0;
   logic        res_is_load = 1'b0;
   logic [1:0]  res_size = '0;
   logic        res_uns = 1'b0;
   logic [1:0]  res_lo = '0;
   logic        lsu_rvalid = 1'b0;
   logic [31:0] lsu_rdata = '0;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err;

   int compared = 0;
   int mismatched = 0;
   int pushed = 0;
   int pulses = 0;
   int waited;
   logic [36:0] sb [$];

   triumph_wb_stage dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .res_valid_i         (res_valid),
      .res_ready_o         (res_ready),
      .res_rd_addr_i       (res_rd),
      .res_data_i          (res_data),
      .res_is_load_i       (res_is_load),
      .res_load_size_i     (res_size),
      .res_load_unsigned_i (res_uns),
      .res_addr_lo_i       (res_lo),
      .lsu_rvalid_i        (lsu_rvalid),
      .lsu_rdata_i         (lsu_rdata),
      .data_valid_wb_o     (wb_valid),
      .rd_addr_wb_o        (wb_rd),
      .rd_data_wb_o        (wb_data),
      .err_o               (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one result, holding it until accepted; loads carry their final expected value.
   task automatic applyStimulus(input logic [4:0] rd, input logic [31:0] data,
                                input logic is_load, input logic [1:0] size,
                                input logic uns, input logic [1:0] lo,
                                input logic [31:0] exp_data, input logic track,
                                output int n);
      res_valid   = 1'b1;
      res_rd      = rd;
      res_data    = data;
      res_is_load = is_load;
      res_size    = size;
      res_uns     = uns;
      res_lo      = lo;
      n = 0;
      while (!res_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) checkOutput("accept_timeout", 32'(n), 32'd0);
      if (track && rd != 5'd0) begin
         sb.push_back({rd, exp_data});
         pushed++;
      end
      tick();
      res_valid = 1'b0;
   endtask

   task automatic lsuRespond(input logic [31:0] data);
      lsu_rvalid = 1'b1;
      lsu_rdata  = data;
      tick();
      lsu_rvalid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && wb_valid) begin
         pulses++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_write", 32'(wb_rd), 32'd0);
         end else begin
            logic [36:0] e;
            e = sb.pop_front();
            checkOutput("wb_rd", 32'(wb_rd), 32'(e[36:32]));
            checkOutput("wb_data", wb_data, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      checkOutput("rst_valid", 32'(wb_valid), 32'd0);
      checkOutput("rst_rd", 32'(wb_rd), 32'd0);
      checkOutput("rst_data", wb_data, 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_ready", 32'(res_ready), 32'd1);

      // ALU stream, one per cycle
      applyStimulus(5'd5, 32'h11, 0, 2'b10, 0, 2'd0, 32'h11, 1, waited);
      checkOutput("stream_lat0", 32'(wb_valid), 32'd0);
      applyStimulus(5'd6, 32'h22, 0, 2'b10, 0, 2'd0, 32'h22, 1, waited);
      checkOutput("stream_wait1", 32'(waited), 32'd0);
      checkOutput("stream_lat1", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd5}));
      applyStimulus(5'd7, 32'h33, 0, 2'b10, 0, 2'd0, 32'h33, 1, waited);
      checkOutput("stream_wait2", 32'(waited), 32'd0);
      checkOutput("stream_p2", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd6}));
      checkOutput("stream_ready", 32'(res_ready), 32'd1);
      tick();
      checkOutput("stream_p3", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd7}));
      tick();
      checkOutput("stream_idle", 32'(wb_valid), 32'd0);

      // Load extension on 0x80F1_7F82
      begin
         logic [1:0]  sz [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
         logic        us [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         logic [1:0]  lo [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
         logic [31:0] ex [6] = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1,
                                 32'h80F1_7F82, 32'h0000_7F82, 32'hFFFF_FF80};
         for (int i = 0; i < 6; i++) begin
            applyStimulus(5'(10 + i), 32'hBAD0_BAD0, 1, sz[i], us[i], lo[i], ex[i], 1, waited);
            lsuRespond(32'h80F1_7F82);
            checkOutput("load_lat0", 32'(wb_valid), 32'd0);
            tick();
            checkOutput("load_valid", 32'(wb_valid), 32'd1);
            checkOutput("load_data", wb_data, ex[i]);
         end
      end

      // Fill head + enqueue, then fill entry 1 + retire entry 0
      applyStimulus(5'd14, 32'h0, 1, 2'b10, 0, 2'd0, 32'hCAFE_F00D, 1, waited);
      fork
         applyStimulus(5'd15, 32'h0, 1, 2'b00, 1, 2'd2, 32'h0000_0034, 1, waited);
         lsuRespond(32'hCAFE_F00D);
      join
      lsuRespond(32'h1234_5678);
      checkOutput("overlap_p1", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd14}));
      tick();
      checkOutput("overlap_p2", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd15}));
      tick();

      // Ordering and stall behind a pending load
      applyStimulus(5'd3, 32'h0, 1, 2'b10, 0, 2'd0, 32'h1, 1, waited);
      applyStimulus(5'd4, 32'hAB, 0, 2'b10, 0, 2'd0, 32'hAB, 1, waited);
      checkOutput("full_ready", 32'(res_ready), 32'd0);
      fork
         applyStimulus(5'd8, 32'h55, 0, 2'b10, 0, 2'd0, 32'h55, 1, waited);
         begin
            repeat (5) tick();
            lsuRespond(32'h1);
         end
      join
      checkOutput("stall_cycles", 32'(waited), 32'd7);
      repeat (3) tick();

      // Write to x0 is consumed silently
      applyStimulus(5'd0, 32'hDEAD, 0, 2'b10, 0, 2'd0, 32'hDEAD, 1, waited);
      applyStimulus(5'd1, 32'h1234, 0, 2'b10, 0, 2'd0, 32'h1234, 1, waited);
      checkOutput("x0_silent", 32'(wb_valid), 32'd0);
      tick();
      checkOutput("x0_next", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd1}));
      tick();

      // Spurious LSU response
      lsuRespond(32'hFFFF);
      checkOutput("err_set", 32'(err), 32'd1);
      applyStimulus(5'd2, 32'h77, 0, 2'b10, 0, 2'd0, 32'h77, 1, waited);
      repeat (3) tick();
      checkOutput("err_sticky", 32'(err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("err_cleared", 32'(err), 32'd0);

      // Reset with two loads in flight
      applyStimulus(5'd20, 32'h0, 1, 2'b10, 0, 2'd0, 32'h0, 0, waited);
      applyStimulus(5'd21, 32'h0, 1, 2'b10, 0, 2'd0, 32'h0, 0, waited);
      checkOutput("midflight_full", 32'(res_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midflight_ready", 32'(res_ready), 32'd1);
      checkOutput("midflight_valid", 32'(wb_valid), 32'd0);
      repeat (4) tick();
      applyStimulus(5'd9, 32'h99, 0, 2'b10, 0, 2'd0, 32'h99, 1, waited);
      tick();
      checkOutput("post_reset", 32'({wb_valid, wb_rd}), 32'({1'b1, 5'd9}));
      repeat (3) tick();

      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      checkOutput("pulse_count", 32'(pulses), 32'(pushed));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/triumph_wb_stage.md
# triumph_wb_stage

Writeback stage of the Triumph core. Accepts completed results from the execute/memory side (ALU results immediately, load results once the LSU returns data) and drives the register-file write port. Results are held in a 2-entry in-order queue, and loads are lane-extracted and sign- or zero-extended. Results retire in program order, at most one per cycle.

## Interface
- No parameters (queue depth fixed at 2, XLEN fixed at 32).
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- res_valid_i  in  1  EX/MEM offers a result this cycle
- res_ready_o  out  1  queue can accept (count < 2); registered-state derived
- res_rd_addr_i  in  5  destination register
- res_data_i  in  32  ALU result (ignored when res_is_load_i=1)
- res_is_load_i  in  1  entry waits for LSU data
- res_load_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- res_load_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend
- res_addr_lo_i  in  2  load address bits [1:0]
- lsu_rvalid_i  in  1  load data valid (one pulse per load, in order)
- lsu_rdata_i  in  32  raw aligned word from memory
- data_valid_wb_o  out  1  register-file write enable (one-cycle pulse)
- rd_addr_wb_o  out  5  register-file write address
- rd_data_wb_o  out  32  register-file write data
- err_o  out  1  sticky; LSU response arrived with no unfilled load pending

## Operation
- Queue entry fields: rd, data, is_load, size, unsigned, addr_lo, filled.
- Enqueue: on an edge with res_valid_i && res_ready_o, the entry is written at the tail. filled=1 if not a load, else 0.
- Fill: on an edge with lsu_rvalid_i, the oldest entry with is_load=1 && filled=0 gets filled=1, and its data becomes the extracted value.
  - Byte: lane = addr_lo; extend bit 7 of the lane.
  - Half: lane = addr_lo[1] (0 = bits 15:0, 1 = bits 31:16); extend bit 15 of the lane.
  - Word: data passes through unchanged. addr_lo is ignored for word and for half bit 0; misalignment is not checked here.
- Fill with no unfilled load pending: the response is dropped and err_o is set to 1 and held until reset.
- Retire: on an edge where the head entry has filled=1, the head is popped and the outputs are registered.
  - data_valid_wb_o = (rd != 0); rd_addr_wb_o = rd; rd_data_wb_o = data.
  - Otherwise data_valid_wb_o = 0, and rd_addr_wb_o / rd_data_wb_o hold their last values.
- Writes to x0 are consumed silently: they pop but data_valid_wb_o=0.
- Simultaneous events on one edge are all allowed:
  - enqueue + retire (count 1 → 1);
  - fill of entry 1 + retire of entry 0;
  - fill of the head + enqueue.
  - A fill and a retire of the same entry on the same edge cannot occur: retire samples the pre-edge filled flag.
- Full: count == 2 forces res_ready_o = 0; no enqueue while full, even if a retire happens the same edge.
- Empty: no retire; data_valid_wb_o = 0.
- Pointers are 1-bit and wrap modulo 2; count ranges 0..2.

## Timing
- Reset values: count=0, pointers=0, all filled=0, data_valid_wb_o=0, rd_addr_wb_o=0, rd_data_wb_o=0, err_o=0, res_ready_o=1 in the cycle after reset.
- ALU result accepted at edge k → data_valid_wb_o high in the cycle after edge k+1 (1-cycle queue latency).
- Load at head, response sampled at edge k → write pulse after edge k+1.
- Back-to-back ALU results sustain one retire per cycle with res_ready_o held at 1.
- Reset mid-operation discards all entries and clears err_o. LSU responses for discarded loads arriving after reset set err_o; the LSU must be reset together with this block.
- res_ready_o is combinational from count only; it has no path from res_valid_i.

## Test plan
- ALU stream: rd=5/6/7 with data 0x11/0x22/0x33, one per cycle → three consecutive pulses with the same values, each one cycle after acceptance; res_ready_o stays 1.
- Load extension: lsu_rdata=0x80F1_7F82.
  - byte, addr_lo=0, signed → 0xFFFF_FF82
  - byte, addr_lo=1, unsigned → 0x0000_007F
  - half, addr_lo=2, signed → 0xFFFF_80F1
  - word → 0x80F1_7F82
- Ordering/stall: load rd=3, then ALU rd=4 (0xAB), then a third offer → third offer held off (res_ready_o=0). LSU data 0x1 returned 5 cycles later → rd=3 written, then rd=4=0xAB on the next cycle, then the third result accepted.
- x0: ALU rd=0 data 0xDEAD → entry pops, data_valid_wb_o never asserted; the following rd=1 retires on the next cycle.
- Spurious response: lsu_rvalid_i with the queue empty → err_o=1 and stays 1. Queue behaviour is unaffected until rst_i, after which err_o=0.
- Reset mid-flight: two loads queued, rst_i pulsed for one cycle → no write pulses, res_ready_o=1; the next ALU result retires normally.
